// File: rtl/apr_fm_par_pkg.sv
// Shared constants and the packed EBUS status image for the APR fast-memory parity checker.
package apr_fm_par_pkg;

    localparam int FM_ADDR_W = 7;
    localparam int FM_WORDS  = 128;
    localparam int FM_SLICES = 6;
    localparam int FM_CNT_W  = 8;

    typedef struct packed {
        logic                 flag;
        logic [1:0]           half;
        logic [FM_ADDR_W-1:0] adr;
        logic [FM_CNT_W-1:0]  cnt;
    } fm_par_status_t;

    localparam int FM_EBUS_W = $bits(fm_par_status_t);

endpackage

// File: rtl/apr_fm_parity_if.sv
// Control/data bundle between the APR/CON/EDP side and the FM parity checker.
// With APR_FM_PAR_INJECT_EN defined, the bundle also carries diag_fm_par_inject_h.
interface apr_fm_parity_if #(
    parameter int ADDR_W = apr_fm_par_pkg::FM_ADDR_W,
    parameter int SLICES = apr_fm_par_pkg::FM_SLICES,
    parameter int CNT_W  = apr_fm_par_pkg::FM_CNT_W
);
    logic [SLICES-1:0] edp_fm_parity_h;
    logic [2:0]        apr_fm_block_h;
    logic [3:0]        apr_fm_adr_h;
    logic              con_fm_write_00to17_l;
    logic              con_fm_write_18to35_l;
    logic              con_fm_read_h;
    logic              con_fm_par_chk_en_h;
    logic              con_clear_fm_par_h;
    logic              diag_read_fm_par_h;
`ifdef APR_FM_PAR_INJECT_EN
    logic              diag_fm_par_inject_h;
`endif
    logic              apr_fm_parity_error_h;
    logic [ADDR_W-1:0] apr_fm_par_err_adr_h;
    logic [1:0]        apr_fm_par_err_half_h;
    logic [CNT_W-1:0]  apr_fm_par_err_cnt_h;
    logic [17:0]       ebus_fm_par_d_h;

    modport master (
`ifdef APR_FM_PAR_INJECT_EN
        output diag_fm_par_inject_h,
`endif
        output edp_fm_parity_h, apr_fm_block_h, apr_fm_adr_h,
        output con_fm_write_00to17_l, con_fm_write_18to35_l, con_fm_read_h,
        output con_fm_par_chk_en_h, con_clear_fm_par_h, diag_read_fm_par_h,
        input  apr_fm_parity_error_h, apr_fm_par_err_adr_h, apr_fm_par_err_half_h,
        input  apr_fm_par_err_cnt_h, ebus_fm_par_d_h
    );

    modport slave (
`ifdef APR_FM_PAR_INJECT_EN
        input  diag_fm_par_inject_h,
`endif
        input  edp_fm_parity_h, apr_fm_block_h, apr_fm_adr_h,
        input  con_fm_write_00to17_l, con_fm_write_18to35_l, con_fm_read_h,
        input  con_fm_par_chk_en_h, con_clear_fm_par_h, diag_read_fm_par_h,
        output apr_fm_parity_error_h, apr_fm_par_err_adr_h, apr_fm_par_err_half_h,
        output apr_fm_par_err_cnt_h, ebus_fm_par_d_h
    );
endinterface

// File: rtl/apr_fm_par_ram.sv
// 1-bit-wide parity store: synchronous write, registered read, write-first on a same-address collision.
module apr_fm_par_ram
    import apr_fm_par_pkg::*;
#(
    parameter int DEPTH = FM_WORDS,
    parameter int AW    = FM_ADDR_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic          wdata,
    input  logic          re,
    output logic          rdata
);

    logic mem [DEPTH];

    // NOTE: the array and its read register carry no reset; software initialises
    // contents, and the checker's own valid bit qualifies every read result.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= we ? wdata : mem[addr];
        end
    end

endmodule

// File: rtl/apr_fm_parity.sv
// FM parity checker: stores per-half parity on writes, checks reads one cycle later, latches first error.
// Optional macro APR_FM_PAR_INJECT_EN adds diag_fm_par_inject_h to corrupt stored parity on writes.
module apr_fm_parity
    import apr_fm_par_pkg::*;
#(
    parameter int ADDR_W = FM_ADDR_W,
    parameter int SLICES = FM_SLICES,
    parameter int CNT_W  = FM_CNT_W
) (
    input  logic            clk_apr_h,
    input  logic            apr_reset_l,
    apr_fm_parity_if.slave  bus
);

    localparam int HALF = SLICES / 2;

    logic [ADDR_W-1:0] addr;
    logic              par_l_now, par_r_now;
    logic              wdata_l, wdata_r;
    logic              stored_l, stored_r;
    logic              err_l, err_r, err_hit;

    logic              rd_valid_q, chk_en_q;
    logic [ADDR_W-1:0] rd_adr_q;

    logic              flag_q;
    logic [ADDR_W-1:0] adr_q;
    logic [1:0]        half_q;
    logic [CNT_W-1:0]  cnt_q;
    fm_par_status_t    status;

    assign addr      = {bus.apr_fm_block_h, bus.apr_fm_adr_h};
    assign par_l_now = ^bus.edp_fm_parity_h[HALF-1:0];
    assign par_r_now = ^bus.edp_fm_parity_h[SLICES-1:HALF];

`ifdef APR_FM_PAR_INJECT_EN
    assign wdata_l = par_l_now ^ bus.diag_fm_par_inject_h;
    assign wdata_r = par_r_now ^ bus.diag_fm_par_inject_h;
`else
    assign wdata_l = par_l_now;
    assign wdata_r = par_r_now;
`endif

    apr_fm_par_ram #(.DEPTH(FM_WORDS), .AW(ADDR_W)) u_ram_l (
        .clk   (clk_apr_h),
        .we    (~bus.con_fm_write_00to17_l),
        .addr  (addr),
        .wdata (wdata_l),
        .re    (bus.con_fm_read_h),
        .rdata (stored_l)
    );

    apr_fm_par_ram #(.DEPTH(FM_WORDS), .AW(ADDR_W)) u_ram_r (
        .clk   (clk_apr_h),
        .we    (~bus.con_fm_write_18to35_l),
        .addr  (addr),
        .wdata (wdata_r),
        .re    (bus.con_fm_read_h),
        .rdata (stored_r)
    );

    // Read data arrives on the slice parity lines the cycle after the read was issued.
    assign err_l   = stored_l != par_l_now;
    assign err_r   = stored_r != par_r_now;
    assign err_hit = rd_valid_q & chk_en_q & (err_l | err_r);

    always_ff @(posedge clk_apr_h) begin
        if (!apr_reset_l) begin
            rd_valid_q <= 1'b0;
            chk_en_q   <= 1'b0;
            rd_adr_q   <= '0;
        end else begin
            rd_valid_q <= bus.con_fm_read_h;
            chk_en_q   <= bus.con_fm_par_chk_en_h;
            if (bus.con_fm_read_h) begin
                rd_adr_q <= addr;
            end
        end
    end

    // Clear outranks a same-cycle error, so a result landing in the clear cycle is dropped.
    always_ff @(posedge clk_apr_h) begin
        if (!apr_reset_l || bus.con_clear_fm_par_h) begin
            flag_q <= 1'b0;
            adr_q  <= '0;
            half_q <= '0;
            cnt_q  <= '0;
        end else if (err_hit) begin
            if (!flag_q) begin
                flag_q <= 1'b1;
                adr_q  <= rd_adr_q;
                half_q <= {err_l, err_r};
            end
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.apr_fm_parity_error_h = flag_q;
    assign bus.apr_fm_par_err_adr_h  = adr_q;
    assign bus.apr_fm_par_err_half_h = half_q;
    assign bus.apr_fm_par_err_cnt_h  = cnt_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        status      = '0;
        status.flag = flag_q;
        status.half = half_q;
        status.adr  = adr_q;
        status.cnt  = cnt_q;
        bus.ebus_fm_par_d_h = '0;
        if (bus.diag_read_fm_par_h) begin
            bus.ebus_fm_par_d_h = status;
        end
    end

endmodule

// File: tb/tb_apr_fm_parity.sv
// Scoreboard bench for apr_fm_parity: per-cycle model expectations queued, monitor compares on falling edges.
module tb_apr_fm_parity;
    import apr_fm_par_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    apr_fm_parity_if bus ();

    apr_fm_parity dut (
        .clk_apr_h   (clk),
        .apr_reset_l (rst_n),
        .bus         (bus)
    );

    typedef struct {
        int       due;
        bit       flag;
        bit [1:0] half;
        bit [6:0] adr;
        bit [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: parity arrays, one outstanding read, and the error status.
    bit       ml [128];
    bit       mr [128];
    bit       pv, pchk, pl, pr;
    bit [6:0] padr;
    bit       m_flag;
    bit [1:0] m_half;
    bit [6:0] m_adr;
    int       m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input bit rst, input bit wl, input bit wr, input bit rd, input bit chk,
                        input bit clr, input bit diag, input bit [6:0] a, input bit [5:0] s,
                        input bit inj);
        bit el, er, injv;
        @(posedge clk);
        #1;
        rst_n                     = ~rst;
        bus.con_fm_write_00to17_l = ~wl;
        bus.con_fm_write_18to35_l = ~wr;
        bus.con_fm_read_h         = rd;
        bus.con_fm_par_chk_en_h   = chk;
        bus.con_clear_fm_par_h    = clr;
        bus.diag_read_fm_par_h    = diag;
        {bus.apr_fm_block_h, bus.apr_fm_adr_h} = a;
        bus.edp_fm_parity_h       = s;
`ifdef APR_FM_PAR_INJECT_EN
        bus.diag_fm_par_inject_h  = inj;
        injv = inj;
`else
        injv = 1'b0;
`endif
        // Result of last cycle's read, judged against this cycle's slice parity.
        el = pv && ((^s[2:0]) != pl);
        er = pv && ((^s[5:3]) != pr);
        if (rst || clr) begin
            m_flag = 0; m_half = 0; m_adr = 0; m_cnt = 0;
        end else if (pchk && (el || er)) begin
            if (!m_flag) begin
                m_flag = 1; m_adr = padr; m_half = {el, er};
            end
            if (m_cnt < 255) m_cnt++;
        end
        if (wl) ml[a] = (^s[2:0]) ^ injv;
        if (wr) mr[a] = (^s[5:3]) ^ injv;
        pv   = rd && !rst;
        pchk = chk;
        padr = a;
        pl   = ml[a];
        pr   = mr[a];
        sb.push_back('{cyc + 1, m_flag, m_half, m_adr, m_cnt[7:0]});
    endtask

    task automatic idle(input bit [5:0] s);
        step(0, 0, 0, 0, 1, 0, 1, 7'($urandom), s, 0);
    endtask

    task automatic rd_op(input bit [6:0] a, input bit [5:0] s);
        step(0, 0, 0, 1, 1, 0, 1, a, s, 0);
    endtask

    task automatic wr_op(input bit [6:0] a, input bit [5:0] s);
        step(0, 1, 1, 0, 1, 0, 1, a, s, 0);
    endtask

    // Monitor: compares every due expectation against the DUT's outputs.
    exp_t        e;
    logic [17:0] ebus_exp;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due != cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_stale: entry due %0d seen at cycle %0d", e.due, cyc);
            end else begin
                ebus_exp = bus.diag_read_fm_par_h ? {e.flag, e.half, e.adr, e.cnt} : 18'h0;
                check("flag", bus.apr_fm_parity_error_h, e.flag);
                check("adr",  bus.apr_fm_par_err_adr_h,  e.adr);
                check("half", bus.apr_fm_par_err_half_h, e.half);
                check("cnt",  bus.apr_fm_par_err_cnt_h,  e.cnt);
                check("ebus", bus.ebus_fm_par_d_h,       ebus_exp);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.con_fm_write_00to17_l = 1'b1;
        bus.con_fm_write_18to35_l = 1'b1;
        bus.con_fm_read_h         = 1'b0;
        bus.con_fm_par_chk_en_h   = 1'b0;
        bus.con_clear_fm_par_h    = 1'b0;
        bus.diag_read_fm_par_h    = 1'b0;
        bus.apr_fm_block_h        = '0;
        bus.apr_fm_adr_h          = '0;
        bus.edp_fm_parity_h       = '0;
`ifdef APR_FM_PAR_INJECT_EN
        bus.diag_fm_par_inject_h  = 1'b0;
`endif
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 1, 0, 1, 7'h01, 6'($urandom), 0);

        for (int a = 0; a < 128; a++) wr_op(7'(a), 6'($urandom));

        // Matching parity: no error.
        wr_op(7'h25, 6'b000111);
        rd_op(7'h25, 6'b000000);
        idle(6'b000111);
        idle(6'b000000);
        @(negedge clk);
        check("t1_flag", bus.apr_fm_parity_error_h, 1'b0);
        check("t1_cnt",  bus.apr_fm_par_err_cnt_h,  8'h00);

        // Left-half mismatch at 7'h10, visible two cycles after the read.
        wr_op(7'h10, 6'b000001);
        rd_op(7'h10, 6'b000000);
        idle(6'b000011);
        @(negedge clk);
        check("t2_not_early", bus.apr_fm_parity_error_h, 1'b0);
        idle(6'b000000);
        @(negedge clk);
        check("t2_flag", bus.apr_fm_parity_error_h, 1'b1);
        check("t2_adr",  bus.apr_fm_par_err_adr_h,  7'h10);
        check("t2_half", bus.apr_fm_par_err_half_h, 2'b10);
        check("t2_cnt",  bus.apr_fm_par_err_cnt_h,  8'h01);

        // Second error keeps first capture.
        wr_op(7'h11, 6'b000000);
        rd_op(7'h11, 6'b000000);
        idle(6'b000001);
        idle(6'b000000);
        @(negedge clk);
        check("t3_adr", bus.apr_fm_par_err_adr_h, 7'h10);
        check("t3_cnt", bus.apr_fm_par_err_cnt_h, 8'h02);

        // Back-to-back failing reads drive the counter into saturation.
        for (int i = 0; i < 300; i++) rd_op(7'h11, 6'b000001);
        idle(6'b000001);
        idle(6'b000000);
        @(negedge clk);
        check("sat_cnt", bus.apr_fm_par_err_cnt_h, 8'hFF);
        step(0, 0, 0, 0, 1, 1, 1, 7'h00, 6'b0, 0);

        // Same-cycle write and read of 7'h3F takes the freshly written parity.
        wr_op(7'h3F, 6'b000111);
        step(0, 1, 1, 1, 1, 0, 1, 7'h3F, 6'b111000, 0);
        idle(6'b111000);
        idle(6'b000000);
        @(negedge clk);
        check("byp_flag", bus.apr_fm_parity_error_h, 1'b0);

        // Clear in the same cycle as a pending error drops it.
        rd_op(7'h11, 6'b000000);
        step(0, 0, 0, 0, 1, 1, 1, 7'h00, 6'b000001, 0);
        idle(6'b000000);
        @(negedge clk);
        check("clr_flag", bus.apr_fm_parity_error_h, 1'b0);
        check("clr_cnt",  bus.apr_fm_par_err_cnt_h,  8'h00);

        // Reset while a failing read is in flight, and a read issued during reset.
        rd_op(7'h11, 6'b000000);
        step(1, 0, 0, 1, 1, 0, 1, 7'h11, 6'b000001, 0);
        idle(6'b000001);
        idle(6'b000000);
        @(negedge clk);
        check("rst_flag", bus.apr_fm_parity_error_h, 1'b0);

`ifdef APR_FM_PAR_INJECT_EN
        step(0, 1, 1, 0, 1, 0, 1, 7'h05, 6'b000111, 1);
        rd_op(7'h05, 6'b000000);
        idle(6'b000111);
        idle(6'b000000);
        @(negedge clk);
        check("inj_flag", bus.apr_fm_parity_error_h, 1'b1);
        check("inj_adr",  bus.apr_fm_par_err_adr_h,  7'h05);
        check("inj_half", bus.apr_fm_par_err_half_h, 2'b11);
        step(0, 0, 0, 0, 1, 1, 1, 7'h00, 6'b0, 0);
`endif

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(199) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
                 $urandom_range(1) == 0, $urandom_range(7) != 0, $urandom_range(63) == 0,
                 1'($urandom), 7'($urandom), 6'($urandom), $urandom_range(7) == 0);
        end

        for (int i = 0; i < 4; i++) idle(6'b000000);
        repeat (3) @(negedge clk);
        check("sb_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
